// File: rtl/io_arb_pkg.sv
// Shared types and constants for the dual-core IO arbiter.
package io_arb_pkg;
    localparam int IO_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        SRC_CORE0 = 1'b0,
        SRC_CORE1 = 1'b1
    } src_t;
endpackage

// File: rtl/io_arbiter_if.sv
// Requester strobes, output handshake and status for io_arbiter.
interface io_arbiter_if
    import io_arb_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic             req0_write;
    logic [WIDTH-1:0] req0_data;
    logic             req1_write;
    logic [WIDTH-1:0] req1_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    src_t             out_src;
    logic [1:0]       ovf;
    logic             ovf_clr;
    logic [LW-1:0]    level0;
    logic [LW-1:0]    level1;

    modport master (
        output req0_write, req0_data, req1_write, req1_data,
        output out_ready, ovf_clr,
        input  out_valid, out_data, out_src, ovf, level0, level1
    );

    modport slave (
        input  req0_write, req0_data, req1_write, req1_data,
        input  out_ready, ovf_clr,
        output out_valid, out_data, out_src, ovf, level0, level1
    );
endinterface

// File: rtl/io_fifo.sv
// Per-requester FIFO; a pop in the same cycle frees room for a push.
module io_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end
endmodule

// File: rtl/io_arbiter.sv
// Two private FIFOs, round-robin grant and a registered output stage.
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = IO_WIDTH
) (
    input logic clk,
    input logic rst,
    io_arbiter_if.slave bus
);
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             full0, full1;
    logic             empty0, empty1;
    logic             pop0, pop1;
    logic             load;
    logic             drop0, drop1;
    src_t             grant;
    src_t             last_grant;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    src_t             out_src;
    logic [1:0]       ovf;

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req0_write),
        .pop   (pop0),
        .wdata (bus.req0_data),
        .rdata (rdata0),
        .full  (full0),
        .empty (empty0),
        .level (bus.level0)
    );

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req1_write),
        .pop   (pop1),
        .wdata (bus.req1_data),
        .rdata (rdata1),
        .full  (full1),
        .empty (empty1),
        .level (bus.level1)
    );

    always_comb begin
        grant = SRC_CORE0;
        if (!empty0 && !empty1)
            grant = (last_grant == SRC_CORE0) ? SRC_CORE1 : SRC_CORE0;
        else if (!empty1)
            grant = SRC_CORE1;
    end

    assign load  = (!out_valid || bus.out_ready) && (!empty0 || !empty1);
    assign pop0  = load && (grant == SRC_CORE0);
    assign pop1  = load && (grant == SRC_CORE1);
    assign drop0 = bus.req0_write && full0 && !pop0;
    assign drop1 = bus.req1_write && full1 && !pop1;

    // last_grant resets to core 1 so core 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= SRC_CORE0;
            last_grant <= SRC_CORE1;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= (grant == SRC_CORE1) ? rdata1 : rdata0;
            out_src    <= grant;
            last_grant <= grant;
        end else if (bus.out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 2'b00;
        else     ovf <= (ovf & {2{~bus.ovf_clr}}) | {drop1, drop0};
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_src   = out_src;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_io_arbiter.sv
// Directed self-checking bench for io_arbiter.
module tb_io_arbiter;
    import io_arb_pkg::*;

    localparam int W = 64;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    io_arbiter_if #(.WIDTH(W), .DEPTH(D)) bus ();

    io_arbiter #(.DEPTH(D), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_write = 1'b0;
        bus.req0_data  = '0;
        bus.req1_write = 1'b0;
        bus.req1_data  = '0;
        bus.out_ready  = 1'b0;
        bus.ovf_clr    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [63:0] exp_d [6];
    logic        exp_s [6];

    initial begin
        idle_inputs();
        do_reset();

        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", bus.out_data, 64'd0);
        check("rst_src", 64'(bus.out_src), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_lvl0", 64'(bus.level0), 64'd0);
        check("rst_lvl1", 64'(bus.level1), 64'd0);

        // single word, 2-cycle latency
        bus.out_ready  = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_data  = 64'h1122334455667788;
        tick();
        bus.req0_write = 1'b0;
        check("sw_lat1", 64'(bus.out_valid), 64'd0);
        tick();
        check("sw_valid", 64'(bus.out_valid), 64'd1);
        check("sw_data", bus.out_data, 64'h1122334455667788);
        check("sw_src", 64'(bus.out_src), 64'd0);
        tick();
        check("sw_drop", 64'(bus.out_valid), 64'd0);

        // contention: both cores strobe 3 cycles
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d[2*i]   = 64'hA0 + 64'(i);
            exp_s[2*i]   = 1'b0;
            exp_d[2*i+1] = 64'hB0 + 64'(i);
            exp_s[2*i+1] = 1'b1;
        end
        for (int c = 1; c <= 8; c++) begin
            bus.req0_write = (c <= 3);
            bus.req1_write = (c <= 3);
            bus.req0_data  = 64'hA0 + 64'(c - 1);
            bus.req1_data  = 64'hB0 + 64'(c - 1);
            tick();
            if (c >= 2 && c <= 7) begin
                check("ct_valid", 64'(bus.out_valid), 64'd1);
                check("ct_src", 64'(bus.out_src), 64'(exp_s[c-2]));
                check("ct_data", bus.out_data, exp_d[c-2]);
            end
        end
        check("ct_end", 64'(bus.out_valid), 64'd0);

        // backpressure
        do_reset();
        bus.req0_write = 1'b1;
        bus.req0_data  = 64'hC0;
        tick();
        bus.req0_data  = 64'hC1;
        tick();
        bus.req0_write = 1'b0;
        check("bp_lvl0", 64'(bus.level0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_v", 64'(bus.out_valid), 64'd1);
            check("bp_hold_d", bus.out_data, 64'hC0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_w1_v", 64'(bus.out_valid), 64'd1);
        check("bp_w1_d", bus.out_data, 64'hC1);
        tick();
        check("bp_end", 64'(bus.out_valid), 64'd0);

        // overflow on req1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.req1_write = 1'b1;
            bus.req1_data  = 64'hD0 + 64'(i);
            tick();
        end
        check("of_lvl1", 64'(bus.level1), 64'd4);
        check("of_ovf", 64'(bus.ovf), 64'b10);
        check("of_out", bus.out_data, 64'hD0);
        check("of_src", 64'(bus.out_src), 64'd1);
        bus.req1_data = 64'hD6;
        bus.ovf_clr   = 1'b1;
        tick();
        check("of_setwins", 64'(bus.ovf), 64'b10);
        check("of_lvl_keep", 64'(bus.level1), 64'd4);
        bus.req1_write = 1'b0;
        tick();
        bus.ovf_clr = 1'b0;
        check("of_clr", 64'(bus.ovf), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("of_drain_v", 64'(bus.out_valid), 64'd1);
            check("of_drain_d", bus.out_data, 64'hD0 + 64'(i));
        end
        tick();
        check("of_end", 64'(bus.out_valid), 64'd0);

        // full FIFO0 with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.req0_write = 1'b1;
            bus.req0_data  = 64'hE0 + 64'(i);
            tick();
        end
        check("fp_full", 64'(bus.level0), 64'd4);
        bus.req0_data = 64'hE5;
        bus.out_ready = 1'b1;
        tick();
        bus.req0_write = 1'b0;
        check("fp_lvl", 64'(bus.level0), 64'd4);
        check("fp_ovf", 64'(bus.ovf), 64'd0);
        check("fp_out", bus.out_data, 64'hE1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("fp_drain", bus.out_data, 64'hE0 + 64'(i));
        end
        tick();
        check("fp_end", 64'(bus.out_valid), 64'd0);

        // reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req0_write = 1'b1;
            bus.req0_data  = 64'hF0 + 64'(i);
            tick();
        end
        bus.req0_write = 1'b0;
        check("rm_lvl_pre", 64'(bus.level0), 64'd3);
        check("rm_v_pre", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rm_v_async", 64'(bus.out_valid), 64'd0);
        check("rm_lvl0", 64'(bus.level0), 64'd0);
        check("rm_lvl1", 64'(bus.level1), 64'd0);
        check("rm_data", bus.out_data, 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("rm_nopulse", 64'(bus.out_valid), 64'd0);
        bus.req0_write = 1'b1;
        bus.req0_data  = 64'h5A5A;
        tick();
        bus.req0_write = 1'b0;
        check("rm_lat1", 64'(bus.out_valid), 64'd0);
        tick();
        check("rm_valid", 64'(bus.out_valid), 64'd1);
        check("rm_word", bus.out_data, 64'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, per-requester FIFO depth in words; power of two, 2..16.
REQ-002 Parameter WIDTH, default 64, data word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0_write  input  1  one-cycle write strobe from core 0, without backpressure.
REQ-006 req0_data  input  WIDTH  core 0 write data, qualified by req0_write.
REQ-007 req1_write  input  1  one-cycle write strobe from core 1, without backpressure.
REQ-008 req1_data  input  WIDTH  core 1 write data, qualified by req1_write.
REQ-009 out_valid  output  1  output word is available.
REQ-010 out_ready  input  1  sink accepts; a transfer occurs when out_valid and out_ready are both high at a posedge.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_src  output  1  source of out_data: 0 = core 0, 1 = core 1.
REQ-013 ovf  output  2  sticky per-requester drop flags; bit n is for requester n.
REQ-014 ovf_clr  input  1  clears both ovf bits.
REQ-015 level0, level1  output  $clog2(DEPTH)+1  current FIFO occupancy for each requester.

Function
REQ-016 Each requester SHALL have a private FIFO; a strobe SHALL push its data at the same posedge.
REQ-017 A push to a full FIFO SHALL be dropped and SHALL set the matching ovf bit; the contents of that FIFO SHALL be unchanged.
REQ-018 A push and a pop in the same cycle on a full FIFO SHALL both succeed, with the level unchanged; "full" for push acceptance SHALL be evaluated after the same-cycle pop.
REQ-019 Output register loads SHALL occur when (!out_valid || out_ready) and at least one FIFO is non-empty.
REQ-020 Each load SHALL pop exactly one word from the granted FIFO.
REQ-021 If no FIFO is non-empty at a load opportunity, out_valid SHALL drop to 0 after a transfer.
REQ-022 Arbitration SHALL be round-robin:
  - when exactly one FIFO is non-empty, it is granted;
  - when both are non-empty, the requester other than last_grant is granted;
  - last_grant updates only on a load.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable and no pop SHALL occur.
REQ-024 Minimum latency SHALL be two cycles: a strobe in cycle k (empty FIFO, idle output) gives out_valid=1 in cycle k+2; one word per cycle thereafter under continuous out_ready.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH and never exceed DEPTH.
REQ-026 Order SHALL be preserved within each requester; no ordering SHALL be guaranteed across requesters.
REQ-027 ovf_clr coinciding with a new drop SHALL leave that ovf bit set (set wins).
REQ-028 Simultaneous strobes from both requesters SHALL both be accepted when neither FIFO is full.

Reset
REQ-029 rst SHALL asynchronously force: out_valid=0, out_data=0, out_src=0, ovf=0, both levels=0, all FIFO pointers=0, last_grant=1 (core 0 is granted first).
REQ-030 Reset mid-operation SHALL discard all buffered words; no out_valid pulse SHALL appear in the first cycle after reset deasserts.
REQ-031 FIFO storage arrays need not be reset.

Structure
REQ-032 The shared package io_arb_pkg SHALL hold:
  - IO_WIDTH=64;
  - the default DEPTH;
  - the source-id type (1 bit, SRC_CORE0=0, SRC_CORE1=1).
REQ-033 The FIFO SHALL be one sub-module, io_fifo (parameters WIDTH, DEPTH; push/pop/data/full/empty/level), instantiated twice.
REQ-034 The arbiter and output register SHALL reside in io_arbiter itself.

Verification
REQ-035 Single word: after reset, req0_write with 0x1122334455667788 and out_ready=1 -> out_valid=1 two cycles later, out_data=0x1122334455667788, out_src=0, for one cycle.
REQ-036 Contention: both strobes in the same cycle (0xA, 0xB), repeated 3 cycles -> outputs alternate src 0,1,0,1,0,1, with data in per-source order.
REQ-037 Backpressure: hold out_ready=0 while queuing 2 words -> out_data is stable across 10 cycles; then raise out_ready -> both words are delivered in consecutive cycles.
REQ-038 Overflow: with out_ready=0, send 6 strobes on req1 (DEPTH=4) -> level1=4, ovf=2'b10, and only the first 4 words plus the word held in the output register emerge; ovf_clr then yields ovf=0.
REQ-039 Full + pop: with FIFO0 full and out_ready=1, a strobe arrives in the same cycle as a pop -> it is accepted, level0 stays 4, and ovf[0]=0.
REQ-040 Reset mid-stream: assert rst while 3 words are queued and out_valid=1 -> out_valid=0 immediately, levels=0, and after release the next strobe is delivered with 2-cycle latency.
